// File: rtl/eq_serial_ctrl_pkg.sv
// Shared types and constants for the bit-serial equality controller.
package eq_serial_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    // Counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction
endpackage

// File: rtl/eq_serial_ctrl_if.sv
// Start/done handshake bundle between the requester and eq_serial_ctrl.
interface eq_serial_ctrl_if
    import eq_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             done_valid;
    logic             done_ready;
    logic             eq_out;
    logic [CNT_W-1:0] bits_checked;
    logic             busy;

    modport master (
        output start_valid, a, b, done_ready,
        input  start_ready, done_valid, eq_out, bits_checked, busy
    );

    modport slave (
        input  start_valid, a, b, done_ready,
        output start_ready, done_valid, eq_out, bits_checked, busy
    );
endinterface

// File: rtl/eq_serial_ctrl_eq_bit_cell.sv
// Shared 1-bit equality cell; the only comparator the controller uses.
module eq_bit_cell (
    input  logic x,
    input  logic y,
    output logic bit_eq
);
    assign bit_eq = (x & y) | (~x & ~y);
endmodule

// File: rtl/eq_serial_ctrl.sv
// Bit-serial word-equality controller, LSB first, one bit per clock.
// Optional macro EQ_SERIAL_EARLY_EXIT_EN ends the scan on the first mismatch.
module eq_serial_ctrl
    import eq_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    eq_serial_ctrl_if.slave  bus
);
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
        $error("eq_serial_ctrl: WIDTH out of range");
    end

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sh_a, r_sh_b;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_eq;
    logic [CNT_W-1:0] r_bits;
    logic             w_bit_eq, w_acc_nxt, w_last, w_scan_end;

    eq_bit_cell u_cell (
        .x      (r_sh_a[0]),
        .y      (r_sh_b[0]),
        .bit_eq (w_bit_eq)
    );

    assign w_acc_nxt = r_acc & w_bit_eq;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
`ifdef EQ_SERIAL_EARLY_EXIT_EN
    assign w_scan_end = w_last | ~w_bit_eq;
`else
    assign w_scan_end = w_last;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start_valid) w_next = SCAN;
            SCAN:    if (w_scan_end)      w_next = DONE;
            DONE:    if (bus.done_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.start_ready = (r_state == IDLE);
        bus.done_valid  = (r_state == DONE);
        bus.busy        = (r_state != IDLE);
    end

    assign bus.eq_out       = r_eq;
    assign bus.bits_checked = r_bits;

    // Result registers only update when a scan ends, so they survive into IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
            r_acc  <= 1'b0;
            r_cnt  <= '0;
            r_eq   <= 1'b0;
            r_bits <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (bus.start_valid) begin
                    r_sh_a <= bus.a;
                    r_sh_b <= bus.b;
                    r_acc  <= 1'b1;
                    r_cnt  <= '0;
                end
                SCAN: begin
                    r_sh_a <= r_sh_a >> 1;
                    r_sh_b <= r_sh_b >> 1;
                    r_acc  <= w_acc_nxt;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_scan_end) begin
                        r_eq   <= w_acc_nxt;
                        r_bits <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Randomized self-checking bench for eq_serial_ctrl against a word-level model.
module tb_eq_serial_ctrl;
    localparam int W  = 8;
`ifdef EQ_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_pass;

    eq_serial_ctrl_if #(.WIDTH(W)) bus ();

    eq_serial_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word-level reference: equality plus the position of the first differing bit.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                  output bit e_eq, output int e_bits);
        logic [W-1:0] d;
        d      = ta ^ tb_;
        e_eq   = (ta == tb_);
        e_bits = W;
        if (EARLY && !e_eq) begin
            for (int i = W - 1; i >= 0; i--)
                if (d[i]) e_bits = i + 1;
        end
    endfunction

    task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int hold);
        bit e_eq;
        int e_bits;
        int lat;
        int n;
        model(ta, tb_, e_eq, e_bits);
        n = 0;
        while (!bus.start_ready && n < 50) begin tick(); n++; end
        chk("start_ready_idle", bus.start_ready, 1);
        bus.a = ta; bus.b = tb_; bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        chk("busy_scan", bus.busy, 1);
        chk("start_ready_scan", bus.start_ready, 0);
        lat = 1;
        while (!bus.done_valid && lat < 100) begin tick(); lat++; end
        chk("latency", lat, e_bits + 1);
        chk("eq_out", bus.eq_out, e_eq);
        chk("bits_checked", bus.bits_checked, e_bits);
        for (int h = 0; h < hold; h++) begin
            bus.start_valid = (h == 1);
            tick();
            bus.start_valid = 1'b0;
            chk("bp_done_valid", bus.done_valid, 1);
            chk("bp_eq_out", bus.eq_out, e_eq);
            chk("bp_bits", bus.bits_checked, e_bits);
            chk("bp_start_ready", bus.start_ready, 0);
        end
        bus.done_ready = 1'b1;
        chk("start_ready_accept_cyc", bus.start_ready, 0);
        tick();
        bus.done_ready = 1'b0;
        chk("start_ready_after", bus.start_ready, 1);
        chk("done_valid_after", bus.done_valid, 0);
        chk("busy_after", bus.busy, 0);
        chk("eq_out_held", bus.eq_out, e_eq);
        chk("bits_held", bus.bits_checked, e_bits);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit seen;
        n_chk = 0; n_pass = 0;
        bus.start_valid = 1'b0; bus.done_ready = 1'b0;
        bus.a = '0; bus.b = '0;
        reset_n = 1'b0;
        #12;
        chk("rst_start_ready", bus.start_ready, 1);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_eq_out", bus.eq_out, 0);
        chk("rst_bits", bus.bits_checked, 0);
        chk("rst_busy", bus.busy, 0);
        tick();
        reset_n = 1'b1;

        // Idle with stray done_ready and operand activity must change nothing.
        bus.done_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.a = W'($urandom); bus.b = W'($urandom);
            tick();
            chk("idle_start_ready", bus.start_ready, 1);
            chk("idle_done_valid", bus.done_valid, 0);
            chk("idle_bits", bus.bits_checked, 0);
        end
        bus.done_ready = 1'b0;

        do_cmp(8'hA5, 8'hA5, 0);
        do_cmp(8'h80, 8'h00, 0);
        do_cmp(8'h01, 8'h00, 5);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            do_cmp(ra, rb, $urandom_range(0, 3));
        end

        // Abort a scan at cycle T+4; reset must clear outputs without a clock.
        do_cmp(8'hA5, 8'hA5, 0);
        bus.a = 8'h3C; bus.b = 8'h3C; bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("abort_start_ready", bus.start_ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done_valid", bus.done_valid, 0);
        chk("abort_eq_out", bus.eq_out, 0);
        chk("abort_bits", bus.bits_checked, 0);
        tick(); tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 0);
        do_cmp(8'hFF, 8'hFF, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/eq_serial_ctrl.md
Name: eq_serial_ctrl

Overview:
- Bit-serial word-equality controller. Accepts two WIDTH-bit operands through a valid/ready handshake.
- Sequences a single shared 1-bit equality cell across the operand bits, LSB first, one bit per clock.
- Returns a registered equal/not-equal result through a second valid/ready handshake.
- Sits between a requesting datapath and the 1-bit comparator. Trades latency for area when wide compares are infrequent.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH)+1: width of the bit counter and of bits_checked.

Ports:
- clk  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start_valid  input  1  requester presents operands a/b
- start_ready  output  1  controller can accept operands
- a  input  WIDTH  operand A, sampled on the start handshake
- b  input  WIDTH  operand B, sampled on the start handshake
- done_valid  output  1  result available
- done_ready  input  1  consumer accepts the result
- eq_out  output  1  1 = all checked bits equal
- bits_checked  output  CNT_W  number of bit positions evaluated
- busy  output  1  high in SCAN or DONE

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low. All flops clear immediately when reset_n=0, regardless of clk.
- Reset values: state=IDLE, start_ready=1 (decoded from state), done_valid=0, eq_out=0, bits_checked=0, busy=0, shift registers=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready at edge T: load a/b into shift registers, set acc=1, set cnt=0, go to SCAN.
  - a/b are ignored at all other times.
- SCAN:
  - start_ready=0.
  - Each cycle, the cell compares sh_a[0] and sh_b[0]. Then acc<=acc&bit_eq, shift both registers right by one, cnt<=cnt+1.
  - Bit i is evaluated in cycle T+1+i.
  - After the cycle that evaluates bit WIDTH-1, go to DONE with eq_out=acc_final and bits_checked=WIDTH.
- DONE:
  - done_valid=1; eq_out and bits_checked are held stable while done_valid=1 and done_ready=0.
  - On done_valid&done_ready: go to IDLE; done_valid<=0.
  - eq_out and bits_checked keep their last value until the next result.
- Latency: done_valid rises in cycle T+WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- No same-cycle turnaround: start_ready is 0 in the DONE cycle where done_ready is accepted, and returns to 1 in the following cycle.
- start_valid asserted outside IDLE has no effect. The requester must hold it until start_ready=1.
- done_ready asserted outside DONE is ignored.
- Counter: cnt wraps only by returning to IDLE; cnt never exceeds WIDTH.
- Reset mid-SCAN or mid-DONE: immediate abort to IDLE. No result is emitted and the partial accumulation is discarded.

Optional Feature:
- Macro: EQ_SERIAL_EARLY_EXIT_EN.
- Defined:
  - The first mismatching bit i ends SCAN; the next state is DONE with eq_out=0 and bits_checked=i+1.
  - Latency on mismatch is i+2 cycles after T.
  - The equal case is unchanged: bits_checked=WIDTH.
- Undefined:
  - All WIDTH bits are always scanned; latency is fixed at WIDTH+1.
  - bits_checked=WIDTH for every result.

Decomposition:
- Package eq_serial_pkg contains:
  - the state enum type (IDLE, SCAN, DONE);
  - a localparam function for CNT_W;
  - the minimum/maximum WIDTH constants used by an elaboration-time width check.
- One sub-module, eq_bit_cell: purely combinational 1-bit equality, bit_eq = (x & y) | (~x & ~y).
  - It is the shared comparator resource and is instantiated once.

Test Plan:
- Reset and idle: reset_n=0 mid-idle -> start_ready=1, done_valid=0, eq_out=0, bits_checked=0. Release reset, start_valid=0 for 20 cycles -> no state change.
- Equal compare: WIDTH=8, a=b=8'hA5, done_ready=1 -> done_valid rises exactly 9 cycles after the start handshake, eq_out=1, bits_checked=8.
- MSB mismatch: a=8'h80, b=8'h00 -> eq_out=0, bits_checked=8 in both builds; latency 9 cycles.
- LSB mismatch: a=8'h01, b=8'h00 -> with EQ_SERIAL_EARLY_EXIT_EN, done_valid at cycle T+2 with bits_checked=1. Without it, T+9 with bits_checked=8. eq_out=0 in both.
- Backpressure: hold done_ready=0 for 5 cycles in DONE -> done_valid, eq_out and bits_checked stable, start_ready=0. A start_valid pulse during this window is not accepted. After done_ready=1, start_ready=1 the following cycle.
- Reset mid-operation: assert reset_n=0 at cycle T+4 of a scan -> state IDLE immediately, done_valid never pulses. A fresh compare a=b=8'hFF then completes with eq_out=1.
